// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receive front end.
// Synchronises and deglitches kclk/kdata, decodes 11-bit frames (start, 8 data LSB-first,
// odd parity, stop) and shifts each good byte into a 32-bit history word.
// Optional macro PS2_PARITY_CHK_EN: when defined, a frame also needs odd parity to be accepted;
// when undefined, the parity bit is sampled but ignored and only the stop bit is checked.
module ps2_rx_frontend #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kclk,
    input  logic        kdata,
    output logic [31:0] keycodeout,
    output logic        newkeypress,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]      FCNT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

`ifdef PS2_PARITY_CHK_EN
    localparam bit PARITY_CHK = 1'b1;
`else
    localparam bit PARITY_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Index 0 carries kclk, index 1 carries kdata.
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] filt_q;
    logic [7:0] fcnt_q [2];
    logic       kclk_prev_q;

    state_e          state_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      shreg_q;
    logic            parity_q;
    logic [TO_W-1:0] tocnt_q;

    logic fall;
    logic kdata_f;
    logic frame_ok;

    assign kdata_f = filt_q[1];
    assign fall    = kclk_prev_q & ~filt_q[0];

    // Parity is only enforced when the check is compiled in; otherwise just the stop bit matters.
    assign frame_ok = kdata_f & ((^{shreg_q, parity_q}) | ~PARITY_CHK);

    assign busy = (state_q != StIdle);

    // Two-flop synchroniser and per-pin run-length filter; a pin changes only after
    // FILTER_LEN consecutive cycles at the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q      <= 2'b11;
            sync_q      <= 2'b11;
            filt_q      <= 2'b11;
            fcnt_q[0]   <= '0;
            fcnt_q[1]   <= '0;
            kclk_prev_q <= 1'b1;
        end else begin
            meta_q      <= {kdata, kclk};
            sync_q      <= meta_q;
            kclk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCNT_LAST) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Frame decoder FSM with registered pulse outputs and inactivity timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            tocnt_q     <= '0;
            keycodeout  <= '0;
            newkeypress <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            newkeypress <= 1'b0;
            frame_err   <= 1'b0;
            if (state_q == StIdle) begin
                tocnt_q <= '0;
                // A fall with kdata high is not a start bit; ignore it silently.
                if (fall && !kdata_f) begin
                    state_q  <= StData;
                    bitcnt_q <= '0;
                end
            end else if (fall) begin
                // A fall takes priority over a timeout landing in the same cycle.
                tocnt_q <= '0;
                case (state_q)
                    StData: begin
                        shreg_q  <= {kdata_f, shreg_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        parity_q <= kdata_f;
                        state_q  <= StStop;
                    end
                    StStop: begin
                        if (frame_ok) begin
                            keycodeout  <= {keycodeout[23:0], shreg_q};
                            newkeypress <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (tocnt_q == TO_LAST) begin
                state_q   <= StIdle;
                frame_err <= 1'b1;
                tocnt_q   <= '0;
            end else begin
                tocnt_q <= tocnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Directed bench for ps2_rx_frontend: table of whole frames plus hand sequences for
// glitch rejection, timeout, stop-bit latency and mid-frame reset.
module tb_ps2_rx_frontend;

    localparam int unsigned FL = 8;
    localparam int unsigned TO = 500;
    localparam int          H  = 40;  // kclk half period in clk cycles

`ifdef PS2_PARITY_CHK_EN
    localparam logic [31:0] KC_BADPAR  = 32'h0000_0000;
    localparam int          NKP_BADPAR = 0;
    localparam int          ERR_BADPAR = 1;
`else
    localparam logic [31:0] KC_BADPAR  = 32'h0000_001C;
    localparam int          NKP_BADPAR = 1;
    localparam int          ERR_BADPAR = 0;
`endif

    logic        clk;
    logic        rst;
    logic        kclk;
    logic        kdata;
    logic [31:0] keycodeout;
    logic        newkeypress;
    logic        frame_err;
    logic        busy;

    ps2_rx_frontend #(
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .kclk       (kclk),
        .kdata      (kdata),
        .keycodeout (keycodeout),
        .newkeypress(newkeypress),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        logic [7:0]  data;
        bit          par;
        bit          stop;
        logic [31:0] kc;
        int          nkp;
        int          err;
    } vec_t;

    vec_t vecs [6];

    int checks = 0;
    int errors = 0;
    int nkp_cnt = 0;
    int err_cnt = 0;
    int busy_cyc = 0;
    int both_cnt = 0;
    logic busy_mid;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (newkeypress) nkp_cnt++;
        if (frame_err) err_cnt++;
        if (busy) busy_cyc++;
        if (newkeypress && frame_err) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        kdata = b;
        wait_cyc(H);
        kclk = 1'b0;
        wait_cyc(H);
        kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        busy_mid = busy;
        send_bit(s);
        kdata = 1'b1;
        wait_cyc(60);
    endtask

    initial begin
        int n0, e0, b0, lat;
        rst   = 1'b1;
        kclk  = 1'b1;
        kdata = 1'b1;
        busy_mid = 1'b0;

        vecs[0] = '{1'b1, 8'h1C, 1'b0, 1'b1, 32'h0000_001C, 1, 0};
        vecs[1] = '{1'b1, 8'hE0, 1'b0, 1'b1, 32'h0000_00E0, 1, 0};
        vecs[2] = '{1'b0, 8'hF0, 1'b1, 1'b1, 32'h0000_E0F0, 1, 0};
        vecs[3] = '{1'b0, 8'h74, 1'b1, 1'b1, 32'h00E0_F074, 1, 0};
        vecs[4] = '{1'b1, 8'h1C, 1'b1, 1'b1, KC_BADPAR, NKP_BADPAR, ERR_BADPAR};
        vecs[5] = '{1'b0, 8'h29, 1'b0, 1'b0, KC_BADPAR, 0, 1};

        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        check("reset keycodeout", keycodeout, 32'h0);
        check("reset newkeypress", {31'd0, newkeypress}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].do_rst) begin
                pulse_rst();
                wait_cyc(2);
            end
            n0 = nkp_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            check($sformatf("row%0d keycodeout", i), keycodeout, vecs[i].kc);
            check($sformatf("row%0d newkeypress count", i), nkp_cnt - n0, vecs[i].nkp);
            check($sformatf("row%0d frame_err count", i), err_cnt - e0, vecs[i].err);
            check($sformatf("row%0d busy mid-frame", i), {31'd0, busy_mid}, 32'd1);
            check($sformatf("row%0d busy after", i), {31'd0, busy}, 32'd0);
        end

        // kclk low glitch one cycle short of the filter length, with kdata low as a start bit.
        pulse_rst();
        wait_cyc(2);
        n0 = nkp_cnt;
        e0 = err_cnt;
        b0 = busy_cyc;
        kdata = 1'b0;
        wait_cyc(20);
        kclk = 1'b0;
        wait_cyc(FL - 1);
        kclk = 1'b1;
        wait_cyc(40);
        kdata = 1'b1;
        wait_cyc(20);
        check("glitch busy cycles", busy_cyc - b0, 32'd0);
        check("glitch frame_err", err_cnt - e0, 32'd0);
        send_frame(8'h29, 1'b0, 1'b1);
        check("after glitch keycodeout", keycodeout, 32'h0000_0029);
        check("after glitch newkeypress", nkp_cnt - n0, 32'd1);

        // Start bit and four data bits, then kclk left high past the timeout.
        n0 = nkp_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        kdata = 1'b1;
        wait_cyc(300);
        check("timeout busy before", {31'd0, busy}, 32'd1);
        check("timeout err before", err_cnt - e0, 32'd0);
        wait_cyc(300);
        check("timeout busy after", {31'd0, busy}, 32'd0);
        check("timeout frame_err count", err_cnt - e0, 32'd1);
        check("timeout newkeypress", nkp_cnt - n0, 32'd0);
        check("timeout keycodeout", keycodeout, 32'h0000_0029);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("after timeout low byte", {24'd0, keycodeout[7:0]}, 32'h5A);
        check("after timeout keycodeout", keycodeout, 32'h0000_295A);

        // Stop-bit latency: pin drop to newkeypress is 2 sync + FL filter + 1 decode cycles.
        n0 = nkp_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i == 2 || i == 3 || i == 4);
        send_bit(1'b0);
        kdata = 1'b1;
        wait_cyc(H);
        kclk = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            wait_cyc(1);
            if (newkeypress && lat == 0) lat = i;
        end
        kclk = 1'b1;
        wait_cyc(60);
        check("stop latency", lat, FL + 3);
        check("latency newkeypress count", nkp_cnt - n0, 32'd1);
        check("latency keycodeout", keycodeout, 32'h0029_5A1C);

        // Reset during the data bits of 0x1C.
        n0 = nkp_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        kdata = 1'b1;
        pulse_rst();
        check("mid reset keycodeout", keycodeout, 32'h0);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        wait_cyc(TO + 20);
        check("mid reset pulses", (nkp_cnt - n0) + (err_cnt - e0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("after reset keycodeout", keycodeout, 32'h0000_001C);
        check("after reset newkeypress", nkp_cnt - n0, 32'd1);

        check("pulses mutually exclusive", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
